// File: rtl/ysyx_22040759_mdu_if.sv
// Request/response handshake bundle between the EXU and the multiply/divide unit.
interface ysyx_22040759_mdu_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_word, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_word, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/ysyx_22040759_mdu.sv
// Multi-cycle RV M-extension unit: radix-2 shift-add multiplier and restoring divider.
// Optional macro YSYX_22040759_MDU_FAST_ZERO_EN short-circuits zero operands to 1-cycle results.
module ysyx_22040759_mdu #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned W_EN = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  ysyx_22040759_mdu_if.slave  bus
);
  localparam int unsigned CW      = $clog2(XLEN + 1);
  localparam int unsigned WSH     = (XLEN > 32) ? XLEN - 32 : 0;
  localparam bit          WORD_OK = (W_EN != 0) && (XLEN == 64);
`ifdef YSYX_22040759_MDU_FAST_ZERO_EN
  localparam bit          FAST_ZERO = 1'b1;
`else
  localparam bit          FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic                word_q, neg_q, neg_r;
  logic [XLEN-1:0]     opnd, quo, rem, res_q;
  logic [2*XLEN-1:0]   prod;

  // Keep the low 32 bits and sign-extend them when running a *W op.
  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN-1:0] t;
    t = v << WSH;
    if (w) return $signed(t) >>> WSH;
    return v;
  endfunction

  // Accept-side decode: operand extension, magnitudes and special cases
  logic            word_en, is_div, is_rem, signed_a, signed_b, sa, sb, spec_hit, accept;
  logic [XLEN-1:0] a_sh, b_sh, ext_a, ext_b, mag_a, mag_b, min_n, spec_val;
  logic [CW-1:0]   n_load;

  always_comb begin
    word_en  = WORD_OK && bus.in_word;
    is_div   = bus.in_op[2];
    is_rem   = bus.in_op[2] & bus.in_op[1];
    signed_a = bus.in_op inside {3'd1, 3'd2, 3'd4, 3'd6};
    signed_b = bus.in_op inside {3'd1, 3'd4, 3'd6};
    a_sh     = bus.in_a << WSH;
    b_sh     = bus.in_b << WSH;
    ext_a    = bus.in_a;
    ext_b    = bus.in_b;
    if (word_en) begin
      if (signed_a) ext_a = $signed(a_sh) >>> WSH;
      else          ext_a = a_sh >> WSH;
      if (signed_b) ext_b = $signed(b_sh) >>> WSH;
      else          ext_b = b_sh >> WSH;
    end
    sa       = signed_a & ext_a[XLEN-1];
    sb       = signed_b & ext_b[XLEN-1];
    mag_a    = sa ? -ext_a : ext_a;
    mag_b    = sb ? -ext_b : ext_b;
    min_n    = {XLEN{1'b1}} << (word_en ? 31 : XLEN - 1);
    n_load   = word_en ? CW'(32) : CW'(XLEN);
    spec_hit = 1'b0;
    spec_val = '0;
    if (is_div && ext_b == '0) begin
      spec_hit = 1'b1;
      spec_val = is_rem ? ext_a : '1;
    end else if (is_div && !bus.in_op[0] && ext_a == min_n && ext_b == '1) begin
      spec_hit = 1'b1;
      spec_val = is_rem ? '0 : ext_a;
    end else if (FAST_ZERO && !is_div && (ext_a == '0 || ext_b == '0)) begin
      spec_hit = 1'b1;
    end else if (FAST_ZERO && is_div && ext_a == '0) begin
      spec_hit = 1'b1;
    end
    accept = (state == IDLE) && bus.in_valid && !flush;
  end

  // One iteration of both engines plus the sign fix-up of the post-iteration values
  logic [XLEN:0]     sum, r_sh;
  logic [2*XLEN-1:0] prod_nxt, prod_raw, prod_f;
  logic [XLEN-1:0]   diff, rem_nxt, quo_nxt, quo_f, rem_f, hi, calc_val;
  logic              ge;

  always_comb begin
    sum      = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opnd};
    prod_nxt = prod[0] ? {sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
    r_sh     = {rem, quo[XLEN-1]};
    ge       = r_sh >= {1'b0, opnd};
    diff     = r_sh[XLEN-1:0] - opnd;
    rem_nxt  = ge ? diff : r_sh[XLEN-1:0];
    quo_nxt  = {quo[XLEN-2:0], ge};
    // In word mode the 32 iterations leave the product sitting WSH bits up.
    prod_raw = word_q ? prod_nxt >> WSH : prod_nxt;
    prod_f   = neg_q ? -prod_raw : prod_raw;
    quo_f    = neg_q ? -quo_nxt : quo_nxt;
    rem_f    = neg_r ? -rem_nxt : rem_nxt;
    hi       = '0;
    if (word_q) hi[31:0] = prod_f[63:32];
    else        hi       = prod_f[2*XLEN-1:XLEN];
    if (op_q[2])          calc_val = op_q[1] ? rem_f : quo_f;
    else if (op_q == '0)  calc_val = prod_f[XLEN-1:0];
    else                  calc_val = hi;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.in_valid) state_nxt = spec_hit ? DONE : CALC;
        CALC:    if (cnt == CW'(1)) state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      op_q   <= '0;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
      res_q  <= '0;
    end else if (accept) begin
      cnt    <= n_load;
      op_q   <= bus.in_op;
      word_q <= word_en;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      opnd   <= is_div ? mag_b : mag_a;
      prod   <= {{XLEN{1'b0}}, mag_b};
      rem    <= '0;
      quo    <= word_en ? mag_a << WSH : mag_a;
      if (spec_hit) res_q <= fin(spec_val, word_en);
    end else if (state == CALC && !flush) begin
      cnt  <= cnt - CW'(1);
      prod <= prod_nxt;
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      if (cnt == CW'(1)) res_q <= fin(calc_val, word_q);
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = res_q;
endmodule
